// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory with a combinational read port.
// Byte and halfword stores are done as read-modify-write of the containing word.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned AW = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STORE  = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4
   } state_t;

   state_t        state, state_d;
   logic [AW-1:0] addr_q, wdata_q, rmw_q;
   logic [2:0]    funct3_q;
   logic          ready_q;
   logic          accept, bad;
   logic          capture, rmw_capture;
   logic          rsp_valid_d, rsp_err_d;
   logic [31:0]   rsp_rdata_d;
   logic [7:0]    byte_lane;
   logic [15:0]   half_lane;
   logic [31:0]   load_val, merged;

   assign accept    = req_valid && ready_q;
   assign req_ready = ready_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};

   // Reject illegal encodings, misaligned accesses and addresses past the memory.
   always_comb begin
      bad = 1'b0;
      if (req_we) begin
         if (req_funct3 > 3'd2) bad = 1'b1;
      end else begin
         if (req_funct3 == 3'd3 || req_funct3 > 3'd5) bad = 1'b1;
      end
      if (req_funct3[1:0] == 2'd1 && req_addr[0]) bad = 1'b1;
      if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00) bad = 1'b1;
      if (req_addr >= AW'(MEM_BYTES)) bad = 1'b1;
   end

   // Lane selection and extension for loads.
   always_comb begin
      byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'd0:    load_val = {{24{byte_lane[7]}}, byte_lane};
         3'd1:    load_val = {{16{half_lane[15]}}, half_lane};
         3'd4:    load_val = {24'd0, byte_lane};
         3'd5:    load_val = {16'd0, half_lane};
         default: load_val = mem_rdata;
      endcase
   end

   // Insert the store lane into the word captured in RMW_RD.
   always_comb begin
      merged = rmw_q;
      if (funct3_q[1:0] == 2'd0) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   // Next state, memory strobes and response values.
   always_comb begin
      state_d     = state;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wdata   = '0;
      capture     = 1'b0;
      rmw_capture = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
      case (state)
         IDLE: begin
            if (accept) begin
               capture = 1'b1;
               if (bad) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else if (!req_we) begin
                  state_d = LOAD;
               end else if (req_funct3 == 3'd2) begin
                  state_d = STORE;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         LOAD: begin
            mem_read    = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = load_val;
            state_d     = IDLE;
         end
         STORE: begin
            mem_write   = 1'b1;
            mem_wdata   = wdata_q;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = IDLE;
         end
         RMW_RD: begin
            mem_read    = 1'b1;
            rmw_capture = 1'b1;
            state_d     = RMW_WR;
         end
         RMW_WR: begin
            mem_write   = 1'b1;
            mem_wdata   = merged;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Ready tracks the state being entered, so it stays low during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         funct3_q  <= '0;
         rmw_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         ready_q   <= (state_d == IDLE);
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
         if (capture) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
         end
         if (rmw_capture) rmw_q <= mem_rdata;
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning data memory size in bytes (power of two, at least 4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, core presents an access.
REQ-005 SHALL have port req_ready, output, 1, unit can accept an access this cycle.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse; no back-pressure.
REQ-011 SHALL have port rsp_rdata, output, 32, extended load result; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, access rejected; qualified by rsp_valid.
REQ-013 SHALL have ports mem_read (output, 1), mem_write (output, 1), mem_addr (output, 32), mem_wdata (output, 32) and mem_rdata (input, 32); these connect to the word data memory, which reads combinationally and writes on the clock edge.

Function
REQ-014 SHALL implement the states IDLE, LOAD, STORE, RMW_RD and RMW_WR.
REQ-015 SHALL assert req_ready only in IDLE; an access is accepted when req_valid and req_ready are both 1, and the accept cycle registers the access.
REQ-016 SHALL flag an accepted access as an error on any of these conditions:
- illegal funct3: load 3, 6 or 7; store 3 or higher.
- misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
- out of range: addr >= MEM_BYTES.
REQ-017 SHALL, for an error access, stay in IDLE, perform no memory access, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0 one cycle after accept.
REQ-018 SHALL take these legal transitions from IDLE: load goes to LOAD; SW goes to STORE; SB or SH goes to RMW_RD. RMW_RD always goes to RMW_WR. LOAD, STORE and RMW_WR return to IDLE.
REQ-019 SHALL drive mem_addr = {addr_q[31:2],2'b00} in every state.
REQ-020 SHALL drive mem_read=1 only in LOAD and RMW_RD, and mem_write=1 only in STORE and RMW_WR; both are decoded from state with no register delay.
REQ-021 SHALL drive mem_wdata=0 except in STORE (the stored word) and RMW_WR (the merged word).
REQ-022 SHALL, in LOAD, select the lane from mem_rdata using addr_q[1:0] (byte) or addr_q[1] (halfword); LB and LH sign-extend, LBU and LHU zero-extend; the result is registered into rsp_rdata.
REQ-023 SHALL, in RMW_RD, capture mem_rdata; in RMW_WR it writes that word with wdata_q[7:0] (SB) or wdata_q[15:0] (SH) replacing only the addressed lane.
REQ-024 SHALL pulse rsp_valid, with rsp_err=0, in the cycle after the final access state.
REQ-025 SHALL achieve these latencies from the accept cycle to rsp_valid: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
REQ-026 SHALL accept a new access in the same cycle rsp_valid is high, giving back-to-back throughput.
REQ-027 SHALL hold rsp_rdata and rsp_err at their last values while rsp_valid=0.
REQ-028 SHALL never write a memory word other than the addressed one, and SHALL never assert mem_read and mem_write in the same cycle.

Reset
REQ-029 SHALL, on rst_n=0 and at any time, immediately force state=IDLE and clear all of the following to 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_wdata and all internal registers.
REQ-030 SHALL drop an access in flight at reset with no response; a reset asserted during RMW_WR deasserts mem_write before the next edge.
REQ-031 SHALL assert req_ready=1 in the first cycle after rst_n rises.

Verification
REQ-032 SHALL cover: word 0x10 = 0x80FF7F01, then LB @0x11, LBU @0x11, LH @0x12 and LHU @0x12 -> rsp_rdata = 0x0000007F, 0x0000007F, 0xFFFF80FF, 0x000080FF respectively, each 2 cycles after accept.
REQ-033 SHALL cover: word 0x20 = 0x11223344, then SB @0x22 with wdata 0xAAAAAA55, then LW @0x20 -> rsp_rdata = 0x11553344; SB response 3 cycles after accept; exactly one mem_write cycle.
REQ-034 SHALL cover: LW @0x6, SH @0x3, load funct3=3 @0x0 and SW @0x1000 (MEM_BYTES=4096) -> rsp_err=1 one cycle after each accept, and mem_read and mem_write stay 0 throughout.
REQ-035 SHALL cover: back-to-back SW @0x40 (0xDEADBEEF) then LW @0x40 with req_valid held -> second accept coincides with the first rsp_valid, and the load returns 0xDEADBEEF.
REQ-036 SHALL cover: SH @0x8 with rst_n pulled low during RMW_WR -> mem_write falls before the next edge, word 0x8 is unchanged, no rsp_valid occurs, and req_ready=1 one cycle after release.
